// File: rtl/instruction_encoder_pkg.sv
// Shared constants and helpers for the instruction encoder: opcode values,
// FIFO geometry and the mode-select decode.
package instruction_encoder_pkg;

  localparam logic [1:0]  OP_MODE0   = 2'b00;
  localparam logic [1:0]  OP_MODE1   = 2'b01;
  localparam logic [1:0]  OP_MODE2   = 2'b10;
  localparam logic [1:0]  OP_MODE3   = 2'b11;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned OPERAND_W  = 6;
  localparam int unsigned INSTR_W    = OPERAND_W + 2;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  function automatic logic is_onehot4(input logic [3:0] m);
    return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful when the select is one-hot.
  function automatic logic [1:0] encode_op(input logic [3:0] m);
    logic [1:0] op;
    op = OP_MODE0;
    if (m[1]) op = OP_MODE1;
    if (m[2]) op = OP_MODE2;
    if (m[3]) op = OP_MODE3;
    return op;
  endfunction

endpackage

// File: rtl/instruction_encoder_fifo.sv
// Synchronous FIFO holding encoded instruction words; pointers wrap naturally,
// storage is not cleared by reset, and the head reads as zero when empty.
module instr_fifo
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_W,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes one-hot mode selects plus operand into 8-bit instructions, queues
// them in a 4-deep FIFO, and counts rejected (non-one-hot) requests.
module instruction_encoder
  import instruction_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 mode0,
  input  logic                 mode1,
  input  logic                 mode2,
  input  logic                 mode3,
  input  logic [OPERAND_W-1:0] operand,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [INSTR_W-1:0]   instruction,
  input  logic                 out_ready,
  output logic                 err,
  output logic [7:0]           err_cnt,
  output logic [CNT_W-1:0]     count
);

  logic [3:0]         modes;
  logic               accept, onehot, push, reject, pop;
  logic               full, empty;
  logic [INSTR_W-1:0] enc_word;
  logic               err_q, err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  assign modes    = {mode3, mode2, mode1, mode0};
  assign onehot   = is_onehot4(modes);
  assign enc_word = {encode_op(modes), operand};

  // Acceptance depends only on occupancy so out_ready never reaches in_ready.
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && onehot;
  assign reject    = accept && !onehot;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  assign err     = err_q;
  assign err_cnt = err_cnt_q;

  always_comb begin
    err_d     = reject;
    err_cnt_d = err_cnt_q;
    if (reject && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (enc_word),
    .pop       (pop),
    .pop_data  (instruction),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized self-checking bench for instruction_encoder against a queue-based model.
module tb_instruction_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode0 = 1'b0, mode1 = 1'b0, mode2 = 1'b0, mode3 = 1'b0;
  logic [5:0] operand = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] instruction;
  logic       out_ready = 1'b0;
  logic       err;
  logic [7:0] err_cnt;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  logic       m_err = 1'b0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .mode0       (mode0),
    .mode1       (mode1),
    .mode2       (mode2),
    .mode3       (mode3),
    .operand     (operand),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .instruction (instruction),
    .out_ready   (out_ready),
    .err         (err),
    .err_cnt     (err_cnt),
    .count       (count)
  );

  // Drives one cycle and advances the reference model across the same edge.
  task automatic drive_cycle(input logic r, input logic v, input logic [3:0] m,
                             input logic [5:0] op, input logic ordy);
    logic       do_pop, acc, ok;
    logic [1:0] opc;
    rst = r; in_valid = v; out_ready = ordy; operand = op;
    {mode3, mode2, mode1, mode0} = m;
    opc = 2'd0;
    for (int i = 0; i < 4; i++) if (m[i]) opc = 2'(i);
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      do_pop = (mq.size() != 0) && ordy;
      acc    = v && (mq.size() != 4);
      ok     = ($countones(m) == 1);
      if (do_pop) void'(mq.pop_front());
      if (acc && ok) mq.push_back({opc, op});
      m_err = acc && !ok;
      if (acc && !ok && m_cnt < 255) m_cnt++;
    end
    #1;
  endtask

  function automatic logic [3:0] bad_modes();
    logic [3:0] m;
    m = 4'($urandom);
    while ($countones(m) == 1) m = 4'($urandom);
    return m;
  endfunction

  task automatic test_reset();
    drive_cycle(1, 0, 4'b0000, 6'h00, 0);
    drive_cycle(1, 1, 4'b0001, 6'h3F, 1);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err got %b/%0d want 0/0", err, err_cnt); end
    n_checks++; if (instruction !== 8'h00) begin n_fail++; $display("FAIL reset_instr got %h want 00", instruction); end
  endtask

  task automatic test_single();
    drive_cycle(0, 1, 4'b0100, 6'h15, 1);
    n_checks++; if (out_valid !== 1'b1 || instruction !== 8'h95) begin n_fail++; $display("FAIL single_out got %b/%h want 1/95", out_valid, instruction); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
    drive_cycle(0, 0, 4'b0000, 6'h00, 1);
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || instruction !== 8'h00) begin
      n_fail++; $display("FAIL single_pop got cnt=%0d ov=%b ins=%h want 0/0/00", count, out_valid, instruction); end
  endtask

  task automatic test_fill();
    logic [7:0] exp_words [4] = '{8'h01, 8'h42, 8'hFF, 8'h80};
    drive_cycle(1, 0, 4'b0000, 6'h00, 0);
    drive_cycle(0, 1, 4'b0001, 6'h01, 0);
    drive_cycle(0, 1, 4'b0010, 6'h02, 0);
    drive_cycle(0, 1, 4'b1000, 6'h3F, 0);
    drive_cycle(0, 1, 4'b0100, 6'h00, 0);
    n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got cnt=%0d rdy=%b want 4/0", count, in_ready); end
    drive_cycle(0, 1, 4'b0011, 6'h2A, 0);
    n_checks++; if (count !== 3'd4 || err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL fill_ignored got cnt=%0d err=%b ec=%0d want 4/0/0", count, err, err_cnt); end
    drive_cycle(0, 1, 4'b0001, 6'h11, 0);
    n_checks++; if (out_valid !== 1'b1 || instruction !== 8'h01) begin n_fail++; $display("FAIL fill_stable got %b/%h want 1/01", out_valid, instruction); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (instruction !== exp_words[i]) begin n_fail++; $display("FAIL drain_%0d got %h want %h", i, instruction, exp_words[i]); end
      drive_cycle(0, 0, 4'b0000, 6'h00, 1);
    end
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got cnt=%0d ov=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_reject();
    drive_cycle(1, 0, 4'b0000, 6'h00, 0);
    drive_cycle(0, 1, 4'b1001, 6'h05, 0);
    n_checks++; if (err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL reject1 got %b/%0d want 1/1", err, err_cnt); end
    drive_cycle(0, 1, 4'b0000, 6'h05, 0);
    n_checks++; if (err !== 1'b1 || err_cnt !== 8'd2) begin n_fail++; $display("FAIL reject2 got %b/%0d want 1/2", err, err_cnt); end
    drive_cycle(0, 0, 4'b0000, 6'h00, 0);
    n_checks++; if (err !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reject_after got err=%b cnt=%0d ov=%b want 0/0/0", err, count, out_valid); end
    drive_cycle(0, 1, 4'b0001, 6'h07, 0);
    drive_cycle(0, 1, 4'b0110, 6'h08, 1);
    n_checks++; if (count !== 3'd0 || err !== 1'b1 || err_cnt !== 8'd3) begin
      n_fail++; $display("FAIL reject_pop got cnt=%0d err=%b ec=%0d want 0/1/3", count, err, err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] m;
    logic [5:0] op;
    drive_cycle(1, 0, 4'b0000, 6'h00, 0);
    drive_cycle(0, 1, 4'b0001, 6'($urandom), 0);
    drive_cycle(0, 1, 4'b0010, 6'($urandom), 0);
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (instruction !== mq[0]) begin n_fail++; $display("FAIL b2b_head_%0d got %h want %h", i, instruction, mq[0]); end
      m  = 4'b0001 << $urandom_range(3, 0);
      op = 6'($urandom);
      drive_cycle(0, 1, m, op, 1);
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count_%0d got %0d want 2", i, count); end
    end
  endtask

  task automatic test_mid_reset();
    drive_cycle(1, 0, 4'b0000, 6'h00, 0);
    drive_cycle(0, 1, 4'b0101, 6'h00, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 4'b1000, 6'(i), 0);
    n_checks++; if (count !== 3'd3 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL prereset got cnt=%0d ec=%0d want 3/1", count, err_cnt); end
    drive_cycle(1, 1, 4'b0010, 6'h09, 1);
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || err_cnt !== 8'd0 || instruction !== 8'h00) begin
      n_fail++; $display("FAIL midreset got cnt=%0d ov=%b ec=%0d ins=%h want 0/0/0/00", count, out_valid, err_cnt, instruction); end
  endtask

  task automatic test_saturate();
    drive_cycle(1, 0, 4'b0000, 6'h00, 0);
    for (int i = 0; i < 300; i++) begin
      drive_cycle(0, 1, bad_modes(), 6'($urandom), 1'($urandom));
      n_checks++; if (err_cnt !== 8'(m_cnt) || err !== 1'b1) begin
        n_fail++; $display("FAIL sat_%0d got ec=%0d err=%b want %0d/1", i, err_cnt, err, m_cnt); end
    end
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_final got %0d want 255", err_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic [7:0] exp_ins;
    drive_cycle(1, 0, 4'b0000, 6'h00, 0);
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(3, 0) == 0) ? bad_modes() : (4'b0001 << $urandom_range(3, 0));
      drive_cycle(1'($urandom_range(60, 0) == 0), 1'($urandom), m, 6'($urandom), ($urandom_range(2, 0) != 0));
      exp_ins = (mq.size() != 0) ? mq[0] : 8'h00;
      n_checks++;
      if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != 4) ||
          instruction !== exp_ins || err !== m_err || err_cnt !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_%0d got cnt=%0d ov=%b rdy=%b ins=%h err=%b ec=%0d want %0d/%b/%b/%h/%b/%0d",
                 i, count, out_valid, in_ready, instruction, err, err_cnt,
                 mq.size(), mq.size() != 0, mq.size() != 4, exp_ins, m_err, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_reject();
    test_back_to_back();
    test_mid_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
